// File: rtl/alu_issue_ctrl.sv
// ALU operand issue controller: accepts requests over valid/ready, holds the
// ALU inputs stable for a settle window, then captures the ALU result into a
// small first-word-fall-through FIFO drained by the consumer.
// SETTLE_CYCLES legal range 1..15; FIFO_DEPTH a power of two, at least 2.
module alu_issue_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [15:0]      req_a,
   input  logic [15:0]      req_b,
   input  logic [2:0]       req_opcode,
   input  logic [2:0]       req_mode,
   output logic [15:0]      alu_a,
   output logic [15:0]      alu_b,
   output logic [2:0]       alu_opcode,
   output logic [2:0]       alu_mode,
   input  logic [31:0]      alu_out,
   input  logic             alu_eq,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic             res_eq,
   output logic             res_za,
   output logic             res_zb,
   output logic [CNT_W-1:0] res_count,
   output logic             busy
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned ENT_W  = 35;

   typedef enum logic [1:0] {StIdle, StDrive, StHold} state_t;

   state_t            state_q, state_d;
   logic [3:0]        settle_q, settle_d;
   logic [15:0]       alu_a_q, alu_b_q;
   logic [2:0]        alu_opcode_q, alu_mode_q;
   logic [CNT_W-1:0]  res_count_q;
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [FCNT_W-1:0] fifo_cnt_q;
   logic [ENT_W-1:0]  mem [FIFO_DEPTH];
   logic [ENT_W-1:0]  head;
   logic [ENT_W-1:0]  push_entry;

   logic accept;
   logic pop;
   logic fifo_full;
   logic push_try;
   logic push;

   assign accept     = req_valid && (state_q == StIdle);
   assign pop        = (fifo_cnt_q != '0) && res_ready;
   assign fifo_full  = (fifo_cnt_q == FCNT_W'(FIFO_DEPTH));
   assign push_try   = ((state_q == StDrive) && (settle_q == 4'd0)) || (state_q == StHold);
   // A full FIFO still takes the push when the head leaves on the same edge.
   assign push       = push_try && (!fifo_full || pop);
   assign push_entry = {alu_out, alu_eq, (alu_a_q == 16'd0), (alu_b_q == 16'd0)};

   // Next-state logic for the issue FSM and the settle down-counter.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d  = StDrive;
               settle_d = 4'(SETTLE_CYCLES - 1);
            end
         end
         StDrive: begin
            if (settle_q != 4'd0) begin
               settle_d = settle_q - 4'd1;
            end else if (push) begin
               state_d = StIdle;
            end else begin
               state_d = StHold;
            end
         end
         StHold: begin
            if (push) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // FSM state and settle counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         settle_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   // Operand registers: loaded on accept, kept afterwards so the ALU stays quiet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a_q      <= 16'd0;
         alu_b_q      <= 16'd0;
         alu_opcode_q <= 3'd0;
         alu_mode_q   <= 3'd0;
      end else if (accept) begin
         alu_a_q      <= req_a;
         alu_b_q      <= req_b;
         alu_opcode_q <= req_opcode;
         alu_mode_q   <= req_mode;
      end
   end

   // Completed-operation counter; wraps silently.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_count_q <= '0;
      end else if (push) begin
         res_count_q <= res_count_q + CNT_W'(1);
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
         end else if (pop && !push) begin
            fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
         end
      end
   end

   // FIFO storage; contents need no reset since outputs are gated by res_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= push_entry;
      end
   end

   assign head       = mem[rd_ptr_q];
   assign res_valid  = (fifo_cnt_q != '0);
   assign res_data   = res_valid ? head[34:3] : 32'd0;
   assign res_eq     = res_valid & head[2];
   assign res_za     = res_valid & head[1];
   assign res_zb     = res_valid & head[0];
   assign res_count  = res_count_q;
   assign req_ready  = (state_q == StIdle);
   assign busy       = (state_q != StIdle);
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_mode   = alu_mode_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a multiply/compare ALU stub on the main
// instance (SETTLE_CYCLES=1) and a second instance (SETTLE_CYCLES=3, CNT_W=3)
// for the settle window and counter wrap.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;

   logic        req_valid, req_ready;
   logic [15:0] req_a, req_b;
   logic [2:0]  req_opcode, req_mode;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_opcode, alu_mode;
   logic [31:0] alu_out;
   logic        alu_eq;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic        res_eq, res_za, res_zb;
   logic [15:0] res_count;
   logic        busy;

   logic        req_valid3, req_ready3;
   logic [15:0] req_a3, req_b3;
   logic [2:0]  req_opcode3, req_mode3;
   logic [15:0] alu_a3, alu_b3;
   logic [2:0]  alu_opcode3, alu_mode3;
   logic [31:0] alu_out3;
   logic        alu_eq3;
   logic        res_valid3, res_ready3;
   logic [31:0] res_data3;
   logic        res_eq3, res_za3, res_zb3;
   logic [2:0]  res_count3;
   logic        busy3;
   logic [31:0] off3;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   assign alu_out  = {16'd0, alu_a} * {16'd0, alu_b};
   assign alu_eq   = (alu_a == alu_b);
   assign alu_out3 = {16'd0, alu_a3} * {16'd0, alu_b3} + off3;
   assign alu_eq3  = (alu_a3 == alu_b3);

   alu_issue_ctrl #(.SETTLE_CYCLES(1), .FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_mode(req_mode),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_mode(alu_mode),
      .alu_out(alu_out), .alu_eq(alu_eq),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_eq(res_eq), .res_za(res_za), .res_zb(res_zb),
      .res_count(res_count), .busy(busy)
   );

   alu_issue_ctrl #(.SETTLE_CYCLES(3), .FIFO_DEPTH(4), .CNT_W(3)) dut3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid3), .req_ready(req_ready3),
      .req_a(req_a3), .req_b(req_b3), .req_opcode(req_opcode3), .req_mode(req_mode3),
      .alu_a(alu_a3), .alu_b(alu_b3), .alu_opcode(alu_opcode3), .alu_mode(alu_mode3),
      .alu_out(alu_out3), .alu_eq(alu_eq3),
      .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
      .res_eq(res_eq3), .res_za(res_za3), .res_zb(res_zb3),
      .res_count(res_count3), .busy(busy3)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] data;
      logic        eq;
      logic        za;
      logic        zb;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one request to the main instance; returns just after the accept edge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      req_a      = a;
      req_b      = b;
      req_opcode = 3'd1;
      req_mode   = 3'd2;
      req_valid  = 1'b1;
      tick();
      req_valid  = 1'b0;
   endtask

   task automatic wait_res();
      int n = 0;
      while (!res_valid && n < 10) begin
         tick();
         n++;
      end
      chk("res_valid_timeout", {31'd0, res_valid}, 32'd1);
   endtask

   task automatic pop_one();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{a: 16'h0000, b: 16'h0000, data: 32'h00000000, eq: 1'b1, za: 1'b1, zb: 1'b1};
      vecs[1] = '{a: 16'h0000, b: 16'h0004, data: 32'h00000000, eq: 1'b0, za: 1'b1, zb: 1'b0};
      vecs[2] = '{a: 16'h0003, b: 16'h0003, data: 32'h00000009, eq: 1'b1, za: 1'b0, zb: 1'b0};
      vecs[3] = '{a: 16'hFFFF, b: 16'h0002, data: 32'h0001FFFE, eq: 1'b0, za: 1'b0, zb: 1'b0};
      vecs[4] = '{a: 16'h0100, b: 16'h0100, data: 32'h00010000, eq: 1'b1, za: 1'b0, zb: 1'b0};
      vecs[5] = '{a: 16'h1234, b: 16'h0000, data: 32'h00000000, eq: 1'b0, za: 1'b0, zb: 1'b1};

      rst = 1'b1;
      req_valid = 1'b0; req_a = '0; req_b = '0; req_opcode = '0; req_mode = '0;
      res_ready = 1'b0;
      req_valid3 = 1'b0; req_a3 = '0; req_b3 = '0; req_opcode3 = '0; req_mode3 = '0;
      res_ready3 = 1'b0; off3 = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_res_count", {16'd0, res_count}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
      chk("rst_res_data", res_data, 32'd0);

      // First op latency: accept at k, result and ready back after k+1
      issue(16'h0005, 16'h0007);
      chk("lat_busy_k", {31'd0, busy}, 32'd1);
      chk("lat_ready_k", {31'd0, req_ready}, 32'd0);
      chk("lat_valid_k", {31'd0, res_valid}, 32'd0);
      chk("lat_alu_a_k", {16'd0, alu_a}, 32'h5);
      tick();
      chk("lat_valid_k1", {31'd0, res_valid}, 32'd1);
      chk("lat_data", res_data, 32'h23);
      chk("lat_eq", {31'd0, res_eq}, 32'd0);
      chk("lat_za", {31'd0, res_za}, 32'd0);
      chk("lat_zb", {31'd0, res_zb}, 32'd0);
      chk("lat_count", {16'd0, res_count}, 32'd1);
      chk("lat_ready_k1", {31'd0, req_ready}, 32'd1);
      chk("idle_alu_a_kept", {16'd0, alu_a}, 32'h5);
      chk("idle_alu_opcode_kept", {29'd0, alu_opcode}, 32'd1);
      pop_one();
      chk("pop_empty", {31'd0, res_valid}, 32'd0);

      // Table-driven operand patterns
      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].a, vecs[i].b);
         wait_res();
         chk($sformatf("vec%0d_data", i), res_data, vecs[i].data);
         chk($sformatf("vec%0d_eq", i), {31'd0, res_eq}, {31'd0, vecs[i].eq});
         chk($sformatf("vec%0d_za", i), {31'd0, res_za}, {31'd0, vecs[i].za});
         chk($sformatf("vec%0d_zb", i), {31'd0, res_zb}, {31'd0, vecs[i].zb});
         pop_one();
      end
      chk("table_count", {16'd0, res_count}, 32'd7);

      // Fill the FIFO with res_ready low; the fifth op stalls in HOLD
      for (int i = 0; i < 5; i++) begin
         issue(16'(i + 1), 16'd10);
      end
      tick();
      tick();
      chk("full_busy", {31'd0, busy}, 32'd1);
      chk("full_ready", {31'd0, req_ready}, 32'd0);
      chk("full_count", {16'd0, res_count}, 32'd11);
      chk("full_head", res_data, 32'd10);
      chk("hold_alu_a", {16'd0, alu_a}, 32'd5);
      pop_one();
      chk("pp_busy", {31'd0, busy}, 32'd0);
      chk("pp_ready", {31'd0, req_ready}, 32'd1);
      chk("pp_count", {16'd0, res_count}, 32'd12);
      for (int i = 1; i < 5; i++) begin
         chk($sformatf("drain%0d_valid", i), {31'd0, res_valid}, 32'd1);
         chk($sformatf("drain%0d_data", i), res_data, 32'((i + 1) * 10));
         pop_one();
      end
      chk("drain_empty", {31'd0, res_valid}, 32'd0);

      // Reset while in DRIVE with two entries queued
      issue(16'd1, 16'd2);
      tick();
      issue(16'd3, 16'd4);
      tick();
      chk("pre_rst_count", {16'd0, res_count}, 32'd14);
      issue(16'd5, 16'd5);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_alu_a", {16'd0, alu_a}, 32'd0);
      chk("arst_alu_b", {16'd0, alu_b}, 32'd0);
      chk("arst_valid", {31'd0, res_valid}, 32'd0);
      chk("arst_data", res_data, 32'd0);
      chk("arst_count", {16'd0, res_count}, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      issue(16'd6, 16'd6);
      wait_res();
      chk("post_rst_data", res_data, 32'd36);
      chk("post_rst_eq", {31'd0, res_eq}, 32'd1);
      chk("post_rst_count", {16'd0, res_count}, 32'd1);
      pop_one();
      chk("post_rst_empty", {31'd0, res_valid}, 32'd0);

      // Settle window of 3: inputs held, late ALU value captured
      req_a3 = 16'd2; req_b3 = 16'd3; req_opcode3 = 3'd5; req_mode3 = 3'd2;
      req_valid3 = 1'b1;
      tick();
      req_valid3 = 1'b0;
      req_a3 = 16'hDEAD; req_b3 = 16'hBEEF; req_opcode3 = 3'd0; req_mode3 = 3'd0;
      off3 = 32'd1;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("s3_c%0d_alu_a", c), {16'd0, alu_a3}, 32'd2);
         chk($sformatf("s3_c%0d_alu_b", c), {16'd0, alu_b3}, 32'd3);
         chk($sformatf("s3_c%0d_opcode", c), {29'd0, alu_opcode3}, 32'd5);
         chk($sformatf("s3_c%0d_mode", c), {29'd0, alu_mode3}, 32'd2);
         chk($sformatf("s3_c%0d_valid", c), {31'd0, res_valid3}, 32'd0);
         tick();
         off3 = 32'(c + 1);
      end
      chk("s3_valid", {31'd0, res_valid3}, 32'd1);
      chk("s3_data", res_data3, 32'd9);
      chk("s3_count", {29'd0, res_count3}, 32'd1);
      off3 = 32'd0;
      res_ready3 = 1'b1;

      // Counter wrap on a 3-bit counter: eight pushes return it to zero
      for (int op = 0; op < 7; op++) begin
         int n = 0;
         while (!req_ready3 && n < 20) begin
            tick();
            n++;
         end
         chk("req_ready3_timeout", {31'd0, req_ready3}, 32'd1);
         req_a3 = 16'(op); req_b3 = 16'd1;
         req_valid3 = 1'b1;
         tick();
         req_valid3 = 1'b0;
         repeat (4) tick();
         if (op == 5) chk("wrap_pre", {29'd0, res_count3}, 32'd7);
      end
      chk("wrap_zero", {29'd0, res_count3}, 32'd0);
      chk("wrap_empty", {31'd0, res_valid3}, 32'd0);
      res_ready3 = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
